// File: rtl/filter_pkg.sv
// Shared defaults and FSM encoding for the alpha-trimmed mean filter datapath.
package filter_pkg;

    localparam int unsigned DefDn    = 25;
    localparam int unsigned DefDw    = 8;
    localparam int unsigned DefTrim  = 4;
    localparam int unsigned DefDwSeq = $clog2(DefDn);
    localparam int unsigned DefK     = DefDn - 2 * DefTrim;
    localparam int unsigned DefWAcc  = DefDw + DefDwSeq;

    localparam logic [3:0] StIdle = 4'b0001;
    localparam logic [3:0] StAcc  = 4'b0010;
    localparam logic [3:0] StDiv  = 4'b0100;
    localparam logic [3:0] StOut  = 4'b1000;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; the start cycle performs the first step.
module serial_divider #(
    parameter int unsigned W_ACC = 13,
    parameter int unsigned DVW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_ACC-1:0] dividend,
    input  logic [DVW-1:0]   divisor,
    output logic             done,
    output logic [W_ACC-1:0] quotient
);

    localparam int unsigned CW = $clog2(W_ACC + 1);

    logic [DVW-1:0]   rem_q, rem_d;
    logic [W_ACC-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;

    logic [DVW-1:0]   rem_in;
    logic             in_bit;
    logic [DVW:0]     trial;
    logic             q_bit;
    logic             last;

    always_comb begin
        rem_in   = start ? '0 : rem_q;
        in_bit   = start ? dividend[W_ACC-1] : q_q[W_ACC-1];
        trial    = {rem_in, in_bit};
        q_bit    = (trial >= {1'b0, divisor});
        last     = start ? (W_ACC == 1) : (cnt_q == CW'(W_ACC - 1));
        rem_d    = rem_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done     = 1'b0;
        if (start || active_q) begin
            // remainder stays below divisor, so the low DVW bits hold it exactly
            rem_d    = q_bit ? DVW'(trial - {1'b0, divisor}) : trial[DVW-1:0];
            q_d      = start ? {dividend[W_ACC-2:0], q_bit} : {q_q[W_ACC-2:0], q_bit};
            cnt_d    = start ? CW'(1) : cnt_q + 1'b1;
            active_d = !last;
            done     = last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign quotient = q_q;

endmodule

// File: rtl/alpha_trim_mean.sv
// Final stage of the alpha-trimmed mean filter: sums the middle K ranks of a sorted window
// and divides by K with round-half-up bias.
module alpha_trim_mean
    import filter_pkg::*;
#(
    parameter int unsigned DN          = DefDn,
    parameter int unsigned DW          = DefDw,
    parameter int unsigned DW_sequence = $clog2(DN),
    parameter int unsigned TRIM        = DefTrim
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DW*DN-1:0]          data_in,
    input  logic [DW_sequence*DN-1:0] seq_in,
    output logic                      busy,
    output logic [DW-1:0]             mean_out,
    output logic                      mean_valid
);

    localparam int unsigned K     = DN - 2 * TRIM;
    localparam int unsigned W_ACC = DW + DW_sequence;
    localparam int unsigned DSW   = DW_sequence;
    localparam int unsigned DVW   = DSW + 1;

    if (2 * TRIM >= DN) begin : g_bad_trim
        $error("alpha_trim_mean: 2*TRIM must be less than DN");
    end

    logic [3:0]       state_q, state_d;
    logic [DW-1:0]    data_q [DN];
    logic [DSW-1:0]   seq_q  [DN];
    logic [W_ACC-1:0] acc_q, acc_d;
    logic [DSW-1:0]   k_q, k_d;
    logic             div_go_q, div_go_d;
    logic [DW-1:0]    mean_q, mean_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [DSW-1:0]   slot;
    logic [DSW-1:0]   idx;
    logic [DW-1:0]    sample;
    logic             div_done;
    logic [W_ACC-1:0] div_quot;

    always_comb begin
        accept = start && (state_q == StIdle);
        slot   = DSW'(TRIM) + k_q;
        idx    = seq_q[slot];
        // out-of-range indices contribute nothing
        sample = (32'(idx) < DN) ? data_q[idx] : '0;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        k_d      = k_q;
        div_go_d = 1'b0;
        mean_d   = mean_q;
        valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAcc;
                    acc_d   = W_ACC'(K / 2);
                    k_d     = '0;
                end
            end
            StAcc: begin
                acc_d = acc_q + W_ACC'(sample);
                k_d   = k_q + 1'b1;
                if (k_q == DSW'(K - 1)) begin
                    state_d  = StDiv;
                    div_go_d = 1'b1;
                end
            end
            StDiv: begin
                if (div_done) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                mean_d  = (|div_quot[W_ACC-1:DW]) ? '1 : div_quot[DW-1:0];
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            k_q      <= '0;
            div_go_q <= 1'b0;
            mean_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            div_go_q <= div_go_d;
            mean_q   <= mean_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DN; i++) begin
                data_q[i] <= '0;
                seq_q[i]  <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DN; i++) begin
                data_q[i] <= data_in[i*DW +: DW];
                seq_q[i]  <= seq_in[i*DSW +: DSW];
            end
        end
    end

    serial_divider #(
        .W_ACC (W_ACC),
        .DVW   (DVW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_go_q),
        .dividend (acc_q),
        .divisor  (DVW'(K)),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign busy       = (state_q != StIdle);
    assign mean_out   = mean_q;
    assign mean_valid = valid_q;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Randomized self-checking bench for alpha_trim_mean against an arithmetic trimmed-mean model.
module tb_alpha_trim_mean;

    localparam int DN   = 25;
    localparam int DW   = 8;
    localparam int SW   = 5;
    localparam int TRIM = 4;
    localparam int K    = DN - 2 * TRIM;
    localparam int LAT  = 31;

    typedef logic [DW-1:0] data_arr_t [DN];
    typedef logic [SW-1:0] seq_arr_t  [DN];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DW*DN-1:0]  data_in = '0;
    logic [SW*DN-1:0]  seq_in = '0;
    logic              busy;
    logic [DW-1:0]     mean_out;
    logic              mean_valid;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  last_mean = '0;

    alpha_trim_mean dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .seq_in     (seq_in),
        .busy       (busy),
        .mean_out   (mean_out),
        .mean_valid (mean_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*DN-1:0] pack_d(input data_arr_t d);
        logic [DW*DN-1:0] p;
        for (int i = 0; i < DN; i++) p[i*DW +: DW] = d[i];
        return p;
    endfunction

    function automatic logic [SW*DN-1:0] pack_s(input seq_arr_t s);
        logic [SW*DN-1:0] p;
        for (int i = 0; i < DN; i++) p[i*SW +: SW] = s[i];
        return p;
    endfunction

    // Indices of d in ascending value order
    function automatic seq_arr_t sort_idx(input data_arr_t d);
        seq_arr_t s;
        int       t;
        for (int i = 0; i < DN; i++) s[i] = SW'(i);
        for (int i = 1; i < DN; i++) begin
            for (int j = i; j > 0 && d[s[j-1]] > d[s[j]]; j--) begin
                t = int'(s[j]);
                s[j] = s[j-1];
                s[j-1] = SW'(t);
            end
        end
        return s;
    endfunction

    function automatic logic [7:0] ref_mean(input data_arr_t d, input seq_arr_t s);
        int sum = 0;
        int m;
        for (int r = TRIM; r < DN - TRIM; r++) begin
            if (int'(s[r]) < DN) sum += int'(d[s[r]]);
        end
        m = (sum + K / 2) / K;
        if (m > 255) m = 255;
        return 8'(m);
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < DN; i++) begin
            data_in[i*DW +: DW] = 8'($urandom());
            seq_in[i*SW +: SW]  = 5'($urandom());
        end
    endtask

    // Called at a negedge; returns at the negedge where mean_valid is seen (or after timeout)
    task automatic do_window(input data_arr_t d, input seq_arr_t s, output logic [7:0] got,
                             output int lat, output bit busy_ok, output bit stable_ok);
        data_in = pack_d(d);
        seq_in  = pack_s(s);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        busy_ok   = (busy === 1'b1);
        stable_ok = 1'b1;
        lat       = -1;
        got       = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (mean_valid === 1'b1) begin
                lat = c;
                got = mean_out;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mean_out !== last_mean) stable_ok = 1'b0;
        end
        if (lat > 0) last_mean = got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
        else n_pass++;
        n_total++;
        if (mean_out !== 8'd0) $display("FAIL reset_mean_out got=%0d want=0", mean_out);
        else n_pass++;
        n_total++;
        if (mean_valid !== 1'b0) $display("FAIL reset_mean_valid got=%b want=0", mean_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        data_arr_t d;
        seq_arr_t  s;
        logic [7:0] got;
        int lat;
        bit bok, sok;
        for (int i = 0; i < DN; i++) begin
            d[i] = 8'(i);
            s[i] = SW'(i);
        end
        do_window(d, s, got, lat, bok, sok);
        n_total++;
        if (got !== 8'd12) $display("FAIL ramp_mean got=%0d want=12", got);
        else n_pass++;
        n_total++;
        if (lat != LAT) $display("FAIL ramp_latency got=%0d want=%0d", lat, LAT);
        else n_pass++;
        n_total++;
        if (!bok) $display("FAIL ramp_busy got=bad want=high_until_valid");
        else n_pass++;
        n_total++;
        if (!sok) $display("FAIL ramp_stable got=changed want=held");
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mean_valid !== 1'b0) $display("FAIL ramp_pulse_width got=%b want=0", mean_valid);
        else n_pass++;
        n_total++;
        if (mean_out !== 8'd12) $display("FAIL ramp_hold got=%0d want=12", mean_out);
        else n_pass++;
    endtask

    task automatic test_flat();
        data_arr_t d;
        seq_arr_t  s;
        logic [7:0] got;
        int lat, j, t;
        bit bok, sok;
        for (int i = 0; i < DN; i++) begin
            d[i] = 8'd200;
            s[i] = SW'(i);
        end
        for (int i = DN - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = int'(s[i]);
            s[i] = s[j];
            s[j] = SW'(t);
        end
        do_window(d, s, got, lat, bok, sok);
        n_total++;
        if (got !== 8'd200) $display("FAIL flat_mean got=%0d want=200", got);
        else n_pass++;
    endtask

    task automatic test_outliers();
        data_arr_t d;
        seq_arr_t  s;
        logic [7:0] got, t;
        int lat, j;
        bit bok, sok;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DN; i++) d[i] = (i < 4) ? 8'd0 : (i < 8) ? 8'd255 : 8'd100;
            if (pass == 1) begin
                for (int i = DN - 1; i > 0; i--) begin
                    j = $urandom_range(i, 0);
                    t = d[i];
                    d[i] = d[j];
                    d[j] = t;
                end
            end
            s = sort_idx(d);
            do_window(d, s, got, lat, bok, sok);
            n_total++;
            if (got !== 8'd100) $display("FAIL outliers_mean pass=%0d got=%0d want=100", pass, got);
            else n_pass++;
        end
    endtask

    task automatic test_rounding();
        data_arr_t d;
        seq_arr_t  s;
        logic [7:0] got;
        int lat;
        bit bok, sok;
        for (int v = 19; v >= 18; v--) begin
            for (int i = 0; i < DN; i++) begin
                d[i] = (i < 4) ? 8'd0 : (i < 20) ? 8'd10 : (i == 20) ? 8'(v) : 8'd255;
                s[i] = SW'(i);
            end
            do_window(d, s, got, lat, bok, sok);
            n_total++;
            if (got !== ((v == 19) ? 8'd11 : 8'd10))
                $display("FAIL rounding_mean v=%0d got=%0d want=%0d", v, got, (v == 19) ? 11 : 10);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        data_arr_t d;
        seq_arr_t  s;
        logic [7:0] got, want;
        int lat;
        bit bok, sok;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < DN; i++) d[i] = 8'($urandom());
            s = sort_idx(d);
            if (it % 4 == 3) s[$urandom_range(DN - TRIM - 1, TRIM)] = SW'($urandom_range(31, DN));
            if (it % 5 == 4) s[TRIM + 1] = s[TRIM + 2];
            want = ref_mean(d, s);
            do_window(d, s, got, lat, bok, sok);
            n_total++;
            if (got !== want || lat != LAT || !bok || !sok)
                $display("FAIL random_window it=%0d got=%0d lat=%0d busy_ok=%0d stable_ok=%0d want=%0d lat=%0d",
                         it, got, lat, bok, sok, want, LAT);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        data_arr_t d;
        int pulses = 0;
        int first_lat = -1;
        logic [7:0] first_val = 'x;
        for (int i = 0; i < DN; i++) begin
            d[i] = 8'(i);
            seq_in[i*SW +: SW] = SW'(i);
        end
        data_in = pack_d(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = (c == 5);
            if (c == 5) data_in = {DN{8'd200}};
            if (mean_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat = c;
                    first_val = mean_out;
                end
            end
        end
        start = 1'b0;
        last_mean = 8'd12;
        n_total++;
        if (pulses != 1) $display("FAIL backpressure_pulses got=%0d want=1", pulses);
        else n_pass++;
        n_total++;
        if (first_val !== 8'd12 || first_lat != LAT)
            $display("FAIL backpressure_result got=%0d@%0d want=12@%0d", first_val, first_lat, LAT);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        data_arr_t d1, d2;
        seq_arr_t  s1, s2;
        logic [7:0] g1, g2, w1, w2;
        int l1, l2;
        bit b1, b2, k1, k2;
        for (int i = 0; i < DN; i++) begin
            d1[i] = 8'($urandom());
            d2[i] = 8'($urandom());
        end
        s1 = sort_idx(d1);
        s2 = sort_idx(d2);
        w1 = ref_mean(d1, s1);
        w2 = ref_mean(d2, s2);
        do_window(d1, s1, g1, l1, b1, k1);
        do_window(d2, s2, g2, l2, b2, k2);
        n_total++;
        if (g1 !== w1 || l1 != LAT) $display("FAIL b2b_first got=%0d@%0d want=%0d@%0d", g1, l1, w1, LAT);
        else n_pass++;
        n_total++;
        if (g2 !== w2 || l2 != LAT) $display("FAIL b2b_second got=%0d@%0d want=%0d@%0d", g2, l2, w2, LAT);
        else n_pass++;
    endtask

    task automatic test_start_in_out();
        data_arr_t d;
        int pulses = 0;
        for (int i = 0; i < DN; i++) begin
            d[i] = 8'd50;
            seq_in[i*SW +: SW] = SW'(i);
        end
        data_in = pack_d(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            start = (c == LAT - 1);
            if (mean_valid === 1'b1) pulses++;
        end
        start = 1'b0;
        last_mean = 8'd50;
        n_total++;
        if (pulses != 1) $display("FAIL start_in_out_pulses got=%0d want=1", pulses);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || mean_out !== 8'd50)
            $display("FAIL start_in_out_idle got=busy%b/%0d want=busy0/50", busy, mean_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        data_arr_t d;
        seq_arr_t  s;
        logic [7:0] got, want;
        int lat;
        int pulses = 0;
        bit bok, sok;
        for (int i = 0; i < DN; i++) d[i] = 8'd90;
        s = sort_idx(d);
        data_in = pack_d(d);
        seq_in = pack_s(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || mean_out !== 8'd0 || mean_valid !== 1'b0)
            $display("FAIL reset_mid_clear got=busy%b mean%0d valid%b want=0/0/0",
                     busy, mean_out, mean_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        last_mean = 8'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mean_valid === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 0) $display("FAIL reset_mid_no_pulse got=%0d want=0", pulses);
        else n_pass++;
        for (int i = 0; i < DN; i++) d[i] = 8'($urandom());
        s = sort_idx(d);
        want = ref_mean(d, s);
        do_window(d, s, got, lat, bok, sok);
        n_total++;
        if (got !== want || lat != LAT || !sok)
            $display("FAIL reset_mid_next got=%0d@%0d want=%0d@%0d", got, lat, want, LAT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_flat();
        test_outliers();
        test_rounding();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_start_in_out();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
